// File: rtl/sop_pkg.sv
// Shared types and constants for the sum-of-products table engine.
// The default mask is built from its minterm list so it reads like the textbook form.
package sop_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sop_state_t;

  localparam int SOP_N_MIN = 2;
  localparam int SOP_N_MAX = 8;

  // Up to eight byte-wide minterm numbers packed LSB-first; the first 'count' are set.
  function automatic logic [255:0] MINTERMS_TO_MASK(input logic [63:0] terms, input int count);
    logic [255:0] mask;
    mask = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < count) mask[terms[8*j +: 8]] = 1'b1;
    end
    return mask;
  endfunction

  function automatic int POPCOUNT_CONST(input logic [255:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 256; i++) c = c + int'(v[i]);
    return c;
  endfunction

  // m(0,2,6,7,9,10,12) -> 16'h16C5
  localparam logic [255:0] SOP_DEFAULT_MASK_W =
    MINTERMS_TO_MASK({8'd0, 8'd12, 8'd10, 8'd9, 8'd7, 8'd6, 8'd2, 8'd0}, 7);
  localparam logic [15:0] SOP_DEFAULT_MASK = SOP_DEFAULT_MASK_W[15:0];

endpackage

// File: rtl/sop_popcount.sv
// Combinational count of set bits in a W-bit vector; the caller registers the result.
module sop_popcount #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < W; i++) w_sum = w_sum + CW'(i_bits[i]);
  end

  assign o_count = w_sum;

endmodule

// File: rtl/sop_table_engine.sv
// Programmable N-input sum-of-products function: live evaluation plus an
// exhaustive (index, value) sweep streamed over a valid/ready handshake.
//
// state | meaning
// IDLE  | mask loads accepted, waiting for sweep_start
// RUN   | streaming minterms 0..2^N-1, counter advances on each handshake
module sop_table_engine
  import sop_pkg::*;
#(
  parameter int              N          = 4,
  parameter logic [2**N-1:0] RESET_MASK = SOP_DEFAULT_MASK
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load_valid,
  output logic         o_load_ready,
  input  logic [N-1:0] i_load_index,
  input  logic         i_load_bit,
  input  logic [N-1:0] i_eval_in,
  output logic         o_eval_out,
  input  logic         i_sweep_start,
  output logic         o_sweep_busy,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_out_index,
  output logic         o_out_value,
  output logic         o_sweep_done,
  output logic [N:0]   o_ones_count
);

  localparam int              M            = 2**N;
  localparam logic [N-1:0]    LAST_INDEX   = '1;
  localparam int              RESET_ONES_I = POPCOUNT_CONST(256'(RESET_MASK));
  localparam logic [N:0]      RESET_ONES   = RESET_ONES_I[N:0];

  if (N < SOP_N_MIN || N > SOP_N_MAX) begin : g_bad_n
    $error("sop_table_engine: N must be within 2..8");
  end

  sop_state_t   r_state;
  logic [M-1:0] r_mask;
  logic [N-1:0] r_cnt;
  logic         r_eval;
  logic         r_done;
  logic [N:0]   r_ones;
  logic [N:0]   w_pop;

  sop_popcount #(.W(M)) u_popcount (
    .i_bits  (r_mask),
    .o_count (w_pop)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_mask  <= RESET_MASK;
      r_cnt   <= '0;
      r_eval  <= RESET_MASK[0];
      r_done  <= 1'b0;
      r_ones  <= RESET_ONES;
    end else begin
      r_done <= 1'b0;
      r_eval <= r_mask[i_eval_in];
      r_ones <= w_pop;
      case (r_state)
        IDLE: begin
          // load and start may coincide; the sweep then reads the updated mask
          if (i_load_valid) r_mask[i_load_index] <= i_load_bit;
          if (i_sweep_start) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          if (i_out_ready) begin
            if (r_cnt == LAST_INDEX) begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_load_ready = (r_state == IDLE) && !i_rst;
  assign o_eval_out   = r_eval;
  assign o_sweep_busy = (r_state == RUN);
  assign o_out_valid  = (r_state == RUN);
  assign o_out_index  = r_cnt;
  assign o_out_value  = r_mask[r_cnt];
  assign o_sweep_done = r_done;
  assign o_ones_count = r_ones;

endmodule

// File: doc/sop_table_engine.md
# sop_table_engine

Parametrised, programmable sum-of-products evaluator: an N-input Boolean function held as a 2^N-bit minterm mask register. It evaluates the function on a live input vector and can autonomously sweep all 2^N input combinations, streaming (index, value) pairs over a valid/ready handshake. It replaces the fixed, combinational 4-input SoP blocks and their hand-written exhaustive testbenches in the logic-function exercises.

## Interface
Parameters:
- N, 4, number of function inputs; legal range 2..8.
- RESET_MASK, 16'h16C5 (m(0,2,6,7,9,10,12)), 2^N-bit mask loaded on reset; bit i = value of minterm i.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  request to write one mask bit.
- load_ready  out  1  high when a load is accepted (IDLE only).
- load_index  in  N  minterm number to write.
- load_bit  in  1  new value for that minterm.
- eval_in  in  N  live input vector; MSB = first variable (x), LSB = last (z).
- eval_out  out  1  registered mask[eval_in].
- sweep_start  in  1  start an exhaustive sweep (IDLE only).
- sweep_busy  out  1  high from the cycle after the accepted start through the final handshake.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accepts.
- out_index  out  N  current input combination.
- out_value  out  1  mask[out_index].
- sweep_done  out  1  one-cycle pulse after the last pair is accepted.
- ones_count  out  N+1  number of set mask bits; range 0..2^N.

## Operation
- State machine: IDLE, RUN.
  - IDLE -> RUN on sweep_start.
  - RUN -> IDLE when out_valid && out_ready && out_index == 2^N-1.
- Load: in IDLE, load_valid && load_ready writes mask[load_index] = load_bit. load_ready = (state == IDLE) && !rst. Loads in RUN are not accepted and are not queued.
- Simultaneous load and sweep_start in IDLE: the load is written and the sweep starts on the same edge. The sweep observes the new mask from index 0.
- sweep_start while in RUN: ignored.
- RUN: out_valid = 1, out_index = counter, out_value = mask[counter].
  - The counter increments on a handshake.
  - out_index and out_value hold stable while out_ready is low.
- Counter wrap: it is cleared to 0 on the final handshake, never wraps to 0 while in RUN.
- ones_count: registered popcount of mask, updated the cycle after any mask change.
- Reset values: mask = RESET_MASK; state = IDLE; counter = 0; eval_out = RESET_MASK[0]; out_valid = 0; sweep_busy = 0; sweep_done = 0; ones_count = popcount(RESET_MASK) (7 for defaults).
- Reset mid-sweep: abort immediately. Outputs take reset values on the next edge; no sweep_done pulse.

## Timing
- eval_out: latency 1 cycle from eval_in. A load to mask[eval_in] is reflected one cycle after the write edge.
- Sweep start accepted at edge k: sweep_busy = 1 and out_valid = 1 with index 0 at cycle k+1.
- With out_ready held high: index i is presented in cycle k+1+i. sweep_done pulses in cycle k+1+2^N, with sweep_busy = 0 in that same cycle. A full sweep takes 2^N+1 cycles.
- Back-pressure: each low cycle of out_ready adds exactly one cycle. There are no bubbles otherwise.
- A new sweep_start is accepted in the cycle sweep_done is high.

## Structure
- Package sop_pkg holds:
  - the state typedef (IDLE, RUN);
  - the N bounds check constants;
  - the default RESET_MASK for N=4;
  - function MINTERMS_TO_MASK, for constant masks.
- Sub-module sop_popcount (parameter W = 2^N): combinational bit count, registered in the top level.
- The top level contains the mask register, FSM, counter and output muxes.

## Test plan
- Reset, N=4 defaults, eval_in swept 0..15 -> eval_out sequence 1,0,1,0,0,0,1,1,0,1,1,0,1,0,0,0 (each one cycle late); ones_count = 7.
- Full sweep with out_ready = 1 -> 16 pairs, index 0..15 matching the above; sweep_done in cycle k+17; sweep_busy high for exactly 16 cycles.
- Sweep with out_ready toggling 1,0 -> each index held during low cycles; 32 stream cycles; no skipped or duplicated index.
- Load mask[5] = 1 and mask[0] = 0 in IDLE -> ones_count = 7 two cycles later; eval_in = 5 gives 1; load during RUN -> load_ready = 0, mask unchanged after the sweep.
- Simultaneous sweep_start and load of mask[0] = 0 -> first streamed pair is (0, 0).
- rst asserted at index 6 of a sweep -> next cycle out_valid = 0, sweep_busy = 0, no sweep_done, mask = 16'h16C5; a new sweep restarts at index 0.
